// File: rtl/uart_tx_sniffer.sv
// Receive-only 8N1 UART decoder that buffers bytes in a first-word-fall-through FIFO.
// Bytes are drained over a valid/ready stream. Framing errors and FIFO overflow are flagged.
module uart_tx_sniffer #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        uart_i,
    output logic                        byte_valid_o,
    output logic [7:0]                  byte_data_o,
    input  logic                        byte_ready_i,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
    output logic                        rx_busy_o,
    output logic                        frame_err_o,
    output logic                        overflow_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = ($clog2(CLK_DIV) > 8) ? $clog2(CLK_DIV) : 8;
    localparam logic [TW-1:0] HALF    = TW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0] FULL    = TW'(CLK_DIV - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state, state_n;
    logic [TW-1:0] tmr, tmr_n;
    logic [2:0]    bitn, bitn_n;
    logic [7:0]    sh, sh_n;
    logic          s_meta, s;
    logic          push, ferr;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr, rd, count;
    logic          full, pop, wr_en;

    // Two-flop synchroniser; idle-high so reset does not look like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            s_meta <= 1'b1;
            s      <= 1'b1;
        end else begin
            s_meta <= uart_i;
            s      <= s_meta;
        end
    end

    always_comb begin
        state_n = state;
        tmr_n   = tmr;
        bitn_n  = bitn;
        sh_n    = sh;
        push    = 1'b0;
        ferr    = 1'b0;
        case (state)
            IDLE: begin
                if (!s) begin
                    tmr_n   = HALF;
                    state_n = START;
                end
            end
            START: begin
                if (tmr == '0) begin
                    if (s) begin
                        state_n = IDLE;
                    end else begin
                        tmr_n   = FULL;
                        bitn_n  = 3'd0;
                        state_n = DATA;
                    end
                end else begin
                    tmr_n = tmr - 1'b1;
                end
            end
            DATA: begin
                if (tmr == '0) begin
                    sh_n  = {s, sh[7:1]};
                    tmr_n = FULL;
                    if (bitn == 3'd7) state_n = STOP;
                    else              bitn_n  = bitn + 3'd1;
                end else begin
                    tmr_n = tmr - 1'b1;
                end
            end
            STOP: begin
                // Leaving at mid-stop gives half a bit of slack before a back-to-back start edge
                if (tmr == '0) begin
                    if (s) begin
                        push    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_n = BREAK;
                    end
                end else begin
                    tmr_n = tmr - 1'b1;
                end
            end
            BREAK: begin
                if (s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tmr   <= '0;
            bitn  <= '0;
            sh    <= '0;
        end else begin
            state <= state_n;
            tmr   <= tmr_n;
            bitn  <= bitn_n;
            sh    <= sh_n;
        end
    end

    assign count = wr - rd;
    assign full  = (count == DEPTH_C);
    assign pop   = byte_valid_o && byte_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr          <= '0;
            rd          <= '0;
            overflow_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            if (wr_en) wr <= wr + 1'b1;
            if (pop)   rd <= rd + 1'b1;
            if (push && full && !pop) overflow_o <= 1'b1;
            frame_err_o <= ferr;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr[AW-1:0]] <= sh;
    end

    assign byte_valid_o = (count != '0);
    assign byte_data_o  = mem[rd[AW-1:0]];
    assign fifo_count_o = count;
    assign rx_busy_o    = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_sniffer.sv
// Bench for uart_tx_sniffer: serial driver with fractional baud, byte-queue reference and pop monitor.
module tb_uart_tx_sniffer;
    localparam int CLK_DIV = 16;
    localparam int DEPTH   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart = 1'b1;
    logic       ready = 1'b0;
    logic       valid, busy, ferr, ovf;
    logic [7:0] data;
    logic [$clog2(DEPTH):0] cnt;

    uart_tx_sniffer #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .uart_i(uart),
        .byte_valid_o(valid), .byte_data_o(data), .byte_ready_i(ready),
        .fifo_count_o(cnt), .rx_busy_o(busy), .frame_err_o(ferr), .overflow_o(ovf)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    int         ferr_cnt = 0;
    int         pops = 0;
    int         acc100 = 0;
    logic [7:0] expq[$];
    logic [7:0] last_pop = 8'h00;
    bit         exp_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted byte is compared against the head of the expected queue
    always @(negedge clk) begin
        if (!rst) begin
            if (ferr) ferr_cnt++;
            if (valid && ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte: got %0h expected none", data);
                end else begin
                    chk("byte_data", data, expq.pop_front());
                end
                last_pop = data;
                pops++;
            end
        end
    end

    task automatic wait_clk();
        @(posedge clk);
        #1;
    endtask

    // Reference: the FIFO is a bounded queue; a byte arriving at a full queue with no reader is lost
    task automatic issue(input logic [7:0] b);
        if (!ready && expq.size() >= DEPTH) exp_ovf = 1'b1;
        else expq.push_back(b);
    endtask

    // One 8N1 frame; per is the bit period in hundredths of a clock, accumulated so drift is exact
    task automatic send_frame(input logic [7:0] b, input bit stopv, input int per);
        logic [9:0] f;
        int nxt;
        f = {stopv, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart = f[i];
            nxt = acc100 + per;
            repeat (nxt / 100 - acc100 / 100) wait_clk();
            acc100 = nxt;
        end
    endtask

    task automatic drain();
        int n;
        ready = 1'b1;
        n = 0;
        while (expq.size() != 0 && n < 400) begin
            wait_clk();
            n++;
        end
        repeat (2) wait_clk();
        ready = 1'b0;
        chk("drain_queue_empty", expq.size(), 0);
        chk("drain_count", cnt, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_clk();
        chk("rst_valid", valid, 0);
        chk("rst_count", cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        expq.delete();
        exp_ovf = 1'b0;
    endtask

    initial begin
        int f0, p0;
        logic [7:0] b;

        repeat (2) wait_clk();
        do_reset();
        repeat (5) wait_clk();

        // Single byte with exact latency
        acc100 = 0;
        issue(8'hA5);
        fork
            send_frame(8'hA5, 1'b1, 1600);
            begin
                repeat (154) wait_clk();
                chk("t1_valid_before", valid, 0);
                wait_clk();
                chk("t1_valid_at", valid, 1);
                chk("t1_data", data, 8'hA5);
                chk("t1_count", cnt, 1);
            end
        join
        ready = 1'b1;
        wait_clk();
        ready = 1'b0;
        wait_clk();
        chk("t1_count_after_pop", cnt, 0);
        chk("t1_queue", expq.size(), 0);

        // Glitch rejection
        repeat (10) wait_clk();
        uart = 1'b0;
        repeat (5) wait_clk();
        uart = 1'b1;
        repeat (30) wait_clk();
        chk("glitch_busy", busy, 0);
        chk("glitch_count", cnt, 0);
        chk("glitch_ferr", ferr_cnt, 0);

        // Framing error then break held low
        acc100 = 0;
        send_frame(8'h3C, 1'b0, 1600);
        repeat (40) wait_clk();
        chk("ferr_pulses", ferr_cnt, 1);
        chk("ferr_count", cnt, 0);
        chk("break_busy", busy, 1);
        uart = 1'b1;
        repeat (5) wait_clk();
        chk("break_exit", busy, 0);
        acc100 = 0;
        issue(8'h41);
        send_frame(8'h41, 1'b1, 1600);
        repeat (20) wait_clk();
        chk("after_break_count", cnt, 1);
        drain();

        // Overflow
        acc100 = 0;
        for (int i = 0; i < 9; i++) begin
            issue(8'(i));
            send_frame(8'(i), 1'b1, 1600);
        end
        repeat (20) wait_clk();
        chk("ovf_count", cnt, expq.size());
        chk("ovf_flag", ovf, exp_ovf);
        drain();
        chk("ovf_sticky", ovf, 1);

        // Reset in the middle of data bit 3
        acc100 = 0;
        fork
            send_frame(8'hFF, 1'b1, 1600);
            begin
                repeat (10 + 16 * 3 + 8) wait_clk();
                do_reset();
            end
        join
        repeat (30) wait_clk();
        p0 = pops;
        acc100 = 0;
        issue(8'h12);
        send_frame(8'h12, 1'b1, 1600);
        repeat (20) wait_clk();
        chk("mid_rst_count", cnt, 1);
        drain();
        chk("mid_rst_one_byte", pops - p0, 1);

        // Full FIFO with a pop on the exact push cycle
        acc100 = 0;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            issue(b);
            send_frame(b, 1'b1, 1600);
        end
        repeat (20) wait_clk();
        chk("full_count", cnt, DEPTH);
        acc100 = 0;
        expq.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1, 1600);
            begin
                repeat (154) wait_clk();
                ready = 1'b1;
                wait_clk();
                ready = 1'b0;
            end
        join
        repeat (20) wait_clk();
        chk("simul_count", cnt, DEPTH);
        chk("simul_ovf", ovf, 0);
        drain();
        chk("simul_last", last_pop, 8'h55);

        // Back-to-back random stream at -3% and +3% baud
        f0 = ferr_cnt;
        ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            acc100 = 0;
            for (int i = 0; i < 32; i++) begin
                b = 8'($urandom);
                issue(b);
                send_frame(b, 1'b1, (k == 0) ? 1552 : 1648);
            end
            repeat (20) wait_clk();
            chk("stream_queue", expq.size(), 0);
        end
        drain();
        chk("stream_ferr", ferr_cnt - f0, 0);
        chk("stream_ovf", ovf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
